motor_cmd_scheduler: RTL and testbench

- Sequences decoded voice/UART motor commands (0-9) into safe motor drive: duty ramping, brake-before-reverse, a dead-time dwell and a latched emergency stop.
- Sits between the command decoder (8-bit command plus valid strobe) and the H-bridge pins.
- Generates a shared PWM plus per-side direction bits.

---
 rtl/motor_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler
// Turns decoded motor commands (0-9) into safe H-bridge drive. Duty ramps
// toward a target at one LSB per RAMP_DIV clocks. A direction change first
// brakes to zero duty and then waits a dead-time dwell. Code 9 latches an
// emergency stop that only code 0 can clear.
//
// Ports:
//   FPGA_CLK1_50 - system clock
//   KEY          - synchronous active-high reset
//   cmd_valid    - command strobe from the decoder
//   command      - command code (0-9 valid, >9 flagged on cmd_err)
//   cmd_ready    - high when a non-estop command can be accepted
//   cmd_err      - one-cycle pulse after an accepted code >9
//   motor_en     - H-bridge enable
//   dir_l/dir_r  - per-side direction, 1 = forward
//   pwm          - shared PWM drive (registered)
//   duty         - currently applied duty
//   state        - FSM state (IDLE=0 RAMP=1 HOLD=2 BRAKE=3 DWELL=4 ESTOP=5)
module motor_cmd_scheduler #(
   parameter int         RAMP_DIV     = 50000,
   parameter int         DWELL_CYCLES = 5000000,
   parameter logic [7:0] DUTY_SLOW    = 8'd64,
   parameter logic [7:0] DUTY_MED     = 8'd128,
   parameter logic [7:0] DUTY_FAST    = 8'd224,
   parameter logic [7:0] DUTY_TURN    = 8'd96
) (
   input  logic       FPGA_CLK1_50,
   input  logic       KEY,
   input  logic       cmd_valid,
   input  logic [7:0] command,
   output logic       cmd_ready,
   output logic       cmd_err,
   output logic       motor_en,
   output logic       dir_l,
   output logic       dir_r,
   output logic       pwm,
   output logic [7:0] duty,
   output logic [2:0] state
);

   localparam int RW = $clog2(RAMP_DIV + 1);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam logic [RW-1:0] RLAST = RW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] DLAST = DW'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RAMP  = 3'd1,
      S_HOLD  = 3'd2,
      S_BRAKE = 3'd3,
      S_DWELL = 3'd4,
      S_ESTOP = 3'd5
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_duty, w_duty_nxt;
   logic [7:0]      r_target, w_target_nxt;
   logic            r_dir_l, r_dir_r, w_dir_l_nxt, w_dir_r_nxt;
   logic            r_pend_l, r_pend_r, w_pend_l_nxt, w_pend_r_nxt;
   logic [7:0]      r_pend_tgt, w_pend_tgt_nxt;
   logic [RW-1:0]   r_rcnt, w_rcnt_nxt;
   logic [DW-1:0]   r_dcnt, w_dcnt_nxt;
   logic            r_en, w_en_nxt;
   logic            r_err;
   logic [7:0]      r_pcnt;
   logic            r_pwm;

   logic            w_ready;
   logic            w_accept;
   logic            w_cmd_ok;
   logic            w_estop;
   logic            w_estop_clr;
   logic            w_err;
   logic            w_tick;
   logic            w_same;
   logic            w_c_l, w_c_r;
   logic [7:0]      w_c_tgt;
   logic [7:0]      w_tgt_eff;
   logic [7:0]      w_step;

   // One LSB toward the target; equal values hold, so no overshoot or wrap.
   function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                              input logic [7:0] tgt);
      if (cur < tgt)      return cur + 8'd1;
      else if (cur > tgt) return cur - 8'd1;
      else                return cur;
   endfunction

   // Command decode. Code 0 keeps the present directions so it never
   // looks like a direction change.
   always_comb begin
      w_c_l   = r_dir_l;
      w_c_r   = r_dir_r;
      w_c_tgt = 8'd0;
      case (command)
         8'd1: begin w_c_l = 1'b1; w_c_r = 1'b1; w_c_tgt = DUTY_SLOW; end
         8'd2: begin w_c_l = 1'b1; w_c_r = 1'b1; w_c_tgt = DUTY_MED;  end
         8'd3: begin w_c_l = 1'b1; w_c_r = 1'b1; w_c_tgt = DUTY_FAST; end
         8'd4: begin w_c_l = 1'b0; w_c_r = 1'b0; w_c_tgt = DUTY_SLOW; end
         8'd5: begin w_c_l = 1'b0; w_c_r = 1'b0; w_c_tgt = DUTY_MED;  end
         8'd6: begin w_c_l = 1'b0; w_c_r = 1'b0; w_c_tgt = DUTY_FAST; end
         8'd7: begin w_c_l = 1'b0; w_c_r = 1'b1; w_c_tgt = DUTY_TURN; end
         8'd8: begin w_c_l = 1'b1; w_c_r = 1'b0; w_c_tgt = DUTY_TURN; end
         default: ;
      endcase
   end

   assign w_ready     = (r_state == S_IDLE) || (r_state == S_RAMP) ||
                        (r_state == S_HOLD);
   assign w_accept    = cmd_valid && w_ready && (command != 8'd9);
   assign w_cmd_ok    = w_accept && (command <= 8'd8);
   assign w_err       = w_accept && (command > 8'd9);
   assign w_estop     = cmd_valid && (command == 8'd9);
   assign w_estop_clr = cmd_valid && (command == 8'd0) && (r_state == S_ESTOP);
   assign w_tick      = (r_rcnt == RLAST);
   assign w_same      = (w_c_l == r_dir_l) && (w_c_r == r_dir_r);

   // Next-state / datapath logic
   always_comb begin
      w_state_nxt    = r_state;
      w_duty_nxt     = r_duty;
      w_target_nxt   = r_target;
      w_dir_l_nxt    = r_dir_l;
      w_dir_r_nxt    = r_dir_r;
      w_pend_l_nxt   = r_pend_l;
      w_pend_r_nxt   = r_pend_r;
      w_pend_tgt_nxt = r_pend_tgt;
      w_dcnt_nxt     = '0;
      w_rcnt_nxt     = '0;
      w_en_nxt       = 1'b0;
      // A command arriving with a ramp tick steers that same step.
      w_tgt_eff      = w_cmd_ok ? w_c_tgt : r_target;
      w_step         = step_toward(r_duty, w_tgt_eff);

      case (r_state)
         S_IDLE: begin
            w_duty_nxt = 8'd0;
            if (w_cmd_ok && (command != 8'd0)) begin
               if (w_same) begin
                  w_target_nxt = w_c_tgt;
                  w_state_nxt  = S_RAMP;
               end else begin
                  w_pend_l_nxt   = w_c_l;
                  w_pend_r_nxt   = w_c_r;
                  w_pend_tgt_nxt = w_c_tgt;
                  w_state_nxt    = S_DWELL;
               end
            end
         end
         S_RAMP, S_HOLD: begin
            if (w_cmd_ok && !w_same) begin
               w_pend_l_nxt   = w_c_l;
               w_pend_r_nxt   = w_c_r;
               w_pend_tgt_nxt = w_c_tgt;
               w_state_nxt    = (r_duty != 8'd0) ? S_BRAKE : S_DWELL;
            end else begin
               w_target_nxt = w_tgt_eff;
               if (r_state == S_HOLD) begin
                  if (w_cmd_ok) w_state_nxt = S_RAMP;
               end else if (w_tick) begin
                  w_duty_nxt = w_step;
                  if (w_step == w_tgt_eff)
                     w_state_nxt = (w_tgt_eff == 8'd0) ? S_IDLE : S_HOLD;
               end
            end
         end
         S_BRAKE: begin
            if (w_tick) begin
               w_duty_nxt = step_toward(r_duty, 8'd0);
               if (w_duty_nxt == 8'd0) w_state_nxt = S_DWELL;
            end
         end
         S_DWELL: begin
            w_duty_nxt = 8'd0;
            if (r_dcnt == DLAST) begin
               w_dir_l_nxt  = r_pend_l;
               w_dir_r_nxt  = r_pend_r;
               w_target_nxt = r_pend_tgt;
               w_state_nxt  = (r_pend_tgt != 8'd0) ? S_RAMP : S_IDLE;
            end else begin
               w_dcnt_nxt = r_dcnt + DW'(1);
            end
         end
         S_ESTOP: begin
            w_duty_nxt = 8'd0;
            if (w_estop_clr) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Emergency stop beats any ramp step or command in the same cycle.
      if (w_estop) begin
         w_state_nxt  = S_ESTOP;
         w_duty_nxt   = 8'd0;
         w_target_nxt = 8'd0;
      end

      // Ramp divider restarts on every entry into RAMP or BRAKE.
      if ((w_state_nxt == r_state) &&
          ((r_state == S_RAMP) || (r_state == S_BRAKE)))
         w_rcnt_nxt = w_tick ? '0 : r_rcnt + RW'(1);

      w_en_nxt = (w_state_nxt == S_RAMP) || (w_state_nxt == S_HOLD) ||
                 (w_state_nxt == S_BRAKE);
   end

   always_ff @(posedge FPGA_CLK1_50) begin
      if (KEY) begin
         r_state    <= S_IDLE;
         r_duty     <= 8'd0;
         r_target   <= 8'd0;
         r_dir_l    <= 1'b1;
         r_dir_r    <= 1'b1;
         r_pend_l   <= 1'b1;
         r_pend_r   <= 1'b1;
         r_pend_tgt <= 8'd0;
         r_rcnt     <= '0;
         r_dcnt     <= '0;
         r_en       <= 1'b0;
         r_err      <= 1'b0;
         r_pcnt     <= 8'd0;
         r_pwm      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_duty     <= w_duty_nxt;
         r_target   <= w_target_nxt;
         r_dir_l    <= w_dir_l_nxt;
         r_dir_r    <= w_dir_r_nxt;
         r_pend_l   <= w_pend_l_nxt;
         r_pend_r   <= w_pend_r_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
         r_rcnt     <= w_rcnt_nxt;
         r_dcnt     <= w_dcnt_nxt;
         r_en       <= w_en_nxt;
         r_err      <= w_err;
         r_pcnt     <= r_pcnt + 8'd1;
         r_pwm      <= r_en && (r_pcnt < r_duty);
      end
   end

   assign cmd_ready = w_ready;
   assign cmd_err   = r_err;
   assign motor_en  = r_en;
   assign dir_l     = r_dir_l;
   assign dir_r     = r_dir_r;
   assign pwm       = r_pwm;
   assign duty      = r_duty;
   assign state     = r_state;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed testbench for motor_cmd_scheduler with RAMP_DIV=2, DWELL_CYCLES=10.
module tb_motor_cmd_scheduler;

   logic       clk;
   logic       key;
   logic       cmd_valid;
   logic [7:0] command;
   logic       cmd_ready;
   logic       cmd_err;
   logic       motor_en;
   logic       dir_l;
   logic       dir_r;
   logic       pwm;
   logic [7:0] duty;
   logic [2:0] state;

   int n_checks = 0;
   int n_errors = 0;

   motor_cmd_scheduler #(
      .RAMP_DIV     (2),
      .DWELL_CYCLES (10)
   ) dut (
      .FPGA_CLK1_50 (clk),
      .KEY          (key),
      .cmd_valid    (cmd_valid),
      .command      (command),
      .cmd_ready    (cmd_ready),
      .cmd_err      (cmd_err),
      .motor_en     (motor_en),
      .dir_l        (dir_l),
      .dir_r        (dir_r),
      .pwm          (pwm),
      .duty         (duty),
      .state        (state)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] c);
      cmd_valid = 1'b1;
      command   = c;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      command   = 8'd0;
   endtask

   task automatic count_pwm(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (pwm) hi++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      int hi;
      key       = 1'b1;
      cmd_valid = 1'b0;
      command   = 8'd0;
      step(2);
      chk("rst_state", state, 0);
      chk("rst_duty", duty, 0);
      chk("rst_en", motor_en, 0);
      chk("rst_dirs", {dir_l, dir_r}, 2'b11);
      chk("rst_pwm", pwm, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_err", cmd_err, 0);
      key = 1'b0;

      // Forward medium ramp to 128
      send(8'd2);
      chk("fwd_state", state, 1);
      chk("fwd_en", motor_en, 1);
      chk("fwd_duty0", duty, 0);
      step(2);
      chk("fwd_duty1", duty, 1);
      step(253);
      chk("fwd_duty127", duty, 127);
      chk("fwd_still_ramp", state, 1);
      step(1);
      chk("fwd_duty128", duty, 128);
      chk("fwd_hold", state, 2);
      count_pwm(256, hi);
      chk("fwd_pwm_hi", hi, 128);

      // Reverse request from HOLD: brake, dwell, then ramp
      send(8'd5);
      chk("rev_brake", state, 3);
      chk("rev_brake_duty", duty, 128);
      chk("rev_brake_ready", cmd_ready, 0);
      step(255);
      chk("rev_duty1", duty, 1);
      chk("rev_dirs_brake", {dir_l, dir_r}, 2'b11);
      step(1);
      chk("rev_dwell", state, 4);
      chk("rev_dwell_en", motor_en, 0);
      chk("rev_dwell_duty", duty, 0);
      step(5);
      chk("dwell_ready", cmd_ready, 0);
      send(8'd1);
      step(3);
      chk("dwell_late", state, 4);
      chk("dwell_dirs", {dir_l, dir_r}, 2'b11);
      step(1);
      chk("rev_ramp", state, 1);
      chk("rev_dirs", {dir_l, dir_r}, 2'b00);
      chk("rev_en", motor_en, 1);
      step(256);
      chk("rev_duty128", duty, 128);
      chk("rev_hold", state, 2);

      // Bad code in HOLD
      send(8'd12);
      chk("err_pulse", cmd_err, 1);
      chk("err_state", state, 2);
      chk("err_duty", duty, 128);
      chk("err_dirs", {dir_l, dir_r}, 2'b00);
      step(1);
      chk("err_clear", cmd_err, 0);

      // Ramp down toward 64, estop at duty 100 on a ramp tick edge
      send(8'd4);
      step(56);
      chk("dn_duty100", duty, 100);
      chk("dn_ramp", state, 1);
      step(1);
      send(8'd9);
      chk("es_state", state, 5);
      chk("es_duty", duty, 0);
      chk("es_en", motor_en, 0);
      chk("es_ready", cmd_ready, 0);
      send(8'd3);
      chk("es_ign3", state, 5);
      chk("es_ign3_duty", duty, 0);
      send(8'd12);
      chk("es_noerr", cmd_err, 0);
      send(8'd0);
      chk("es_exit", state, 0);
      chk("es_exit_dirs", {dir_l, dir_r}, 2'b00);
      count_pwm(256, hi);
      chk("idle_pwm", hi, 0);

      // Reset in the middle of a dwell
      send(8'd1);
      chk("rd_dwell", state, 4);
      step(3);
      key = 1'b1;
      step(1);
      chk("rd_state", state, 0);
      chk("rd_dirs", {dir_l, dir_r}, 2'b11);
      chk("rd_duty", duty, 0);
      chk("rd_ready", cmd_ready, 1);
      key = 1'b0;

      // Reset in the middle of a ramp
      send(8'd2);
      step(20);
      chk("rr_duty10", duty, 10);
      key = 1'b1;
      step(1);
      chk("rr_state", state, 0);
      chk("rr_duty", duty, 0);
      chk("rr_en", motor_en, 0);
      chk("rr_pwm", pwm, 0);
      key = 1'b0;

      // Pivot left from IDLE, then stop back to IDLE
      send(8'd7);
      chk("pl_dwell", state, 4);
      step(9);
      chk("pl_dwell_end", state, 4);
      chk("pl_dirs_old", {dir_l, dir_r}, 2'b11);
      step(1);
      chk("pl_ramp", state, 1);
      chk("pl_dirs", {dir_l, dir_r}, 2'b01);
      chk("pl_en", motor_en, 1);
      step(192);
      chk("pl_duty96", duty, 96);
      chk("pl_hold", state, 2);
      send(8'd0);
      chk("st_ramp", state, 1);
      step(191);
      chk("st_duty1", duty, 1);
      chk("st_en1", motor_en, 1);
      step(1);
      chk("st_duty0", duty, 0);
      chk("st_idle", state, 0);
      chk("st_en0", motor_en, 0);
      chk("st_dirs", {dir_l, dir_r}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
